// File: rtl/s_term_dsp_loopback_if.sv
// Bus bundle for the S-terminal DSP loopback tile: S-wires in, N-wires out,
// config shift chain and built-in test controls.
interface s_term_dsp_loopback_if;
    localparam int unsigned W1    = 4;
    localparam int unsigned W2    = 8;
    localparam int unsigned W4    = 16;
    localparam int unsigned LEN_W = 8;

    // S-side inputs into the tile
    logic [W1-1:0]    S1END;
    logic [W2-1:0]    S2MID;
    logic [W2-1:0]    S2END;
    logic [W4-1:0]    S4END;
    logic [W4-1:0]    SS4END;

    // N-side outputs from the tile
    logic [W1-1:0]    N1BEG;
    logic [W2-1:0]    N2BEG;
    logic [W2-1:0]    N2BEGb;
    logic [W4-1:0]    N4BEG;
    logic [W4-1:0]    NN4BEG;

    // Config shift chain
    logic             cfg_shift;
    logic             cfg_din;
    logic             cfg_load;
    logic             cfg_dout;

    // Built-in test
    logic             test_start;
    logic [LEN_W-1:0] test_len;
    logic             test_busy;
    logic             test_done;
    logic [W4-1:0]    sig_out;

    // Side that drives the S-wires, config and test controls
    modport master (
        output S1END, S2MID, S2END, S4END, SS4END,
        output cfg_shift, cfg_din, cfg_load,
        output test_start, test_len,
        input  N1BEG, N2BEG, N2BEGb, N4BEG, NN4BEG,
        input  cfg_dout, test_busy, test_done, sig_out
    );

    // The loopback tile itself
    modport slave (
        input  S1END, S2MID, S2END, S4END, SS4END,
        input  cfg_shift, cfg_din, cfg_load,
        input  test_start, test_len,
        output N1BEG, N2BEG, N2BEGb, N4BEG, NN4BEG,
        output cfg_dout, test_busy, test_done, sig_out
    );
endinterface

// File: rtl/s_term_dsp_loopback.sv
// S-terminal DSP loopback tile: reverses each S-wire group onto its N-wire
// twin, with a per-group optional pipeline stage chosen by a shifted-in
// config word, plus an LFSR pattern generator / signature test mode.
module s_term_dsp_loopback #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  UserCLK,
    input  logic                  resetn,
    s_term_dsp_loopback_if.slave  bus
);
    localparam int unsigned W1    = 4;
    localparam int unsigned W2    = 8;
    localparam int unsigned W4    = 16;
    localparam int unsigned CFG_W = 4;
    localparam int unsigned LEN_W = 8;
    localparam logic [W4-1:0] SIG_POLY = 16'h6801;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    logic [W1-1:0]    m1;
    logic [W2-1:0]    m2;
    logic [W2-1:0]    m2b;
    logic [W4-1:0]    m4;
    logic [W4-1:0]    mm4;

    logic [CFG_W-1:0] cfg_sr_q;
    logic [CFG_W-1:0] cfg_act_q;

    logic [W1-1:0]    p1_q;
    logic [W2-1:0]    p2_q;
    logic [W2-1:0]    p2b_q;
    logic [W4-1:0]    p4_q;
    logic [W4-1:0]    pp4_q;

    state_e           state_q;
    logic [LEN_W-1:0] cnt_q;
    logic [W4-1:0]    lfsr_q;
    logic [W4-1:0]    sig_q;
    logic             busy_q;
    logic             done_q;

    logic             lfsr_fb;
    logic [W4-1:0]    sig_d;

    logic [W1-1:0]    n1_c;
    logic [W2-1:0]    n2_c;
    logic [W2-1:0]    n2b_c;
    logic [W4-1:0]    n4_c;
    logic [W4-1:0]    nn4_c;

    // Bit-reversed mapping of each S-wire group onto its N-wire order
    always_comb begin
        m1  = '0;
        m2  = '0;
        m2b = '0;
        m4  = '0;
        mm4 = '0;
        for (int i = 0; i < int'(W1); i++) m1[i]  = bus.S1END[int'(W1) - 1 - i];
        for (int i = 0; i < int'(W2); i++) m2[i]  = bus.S2MID[int'(W2) - 1 - i];
        for (int i = 0; i < int'(W2); i++) m2b[i] = bus.S2END[int'(W2) - 1 - i];
        for (int i = 0; i < int'(W4); i++) m4[i]  = bus.S4END[int'(W4) - 1 - i];
        for (int i = 0; i < int'(W4); i++) mm4[i] = bus.SS4END[int'(W4) - 1 - i];
    end

    // Config shift chain; a load in the same cycle as a shift captures the pre-shift word
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            cfg_sr_q  <= '0;
            cfg_act_q <= '0;
        end else begin
            if (bus.cfg_shift) cfg_sr_q  <= {cfg_sr_q[CFG_W-2:0], bus.cfg_din};
            if (bus.cfg_load)  cfg_act_q <= cfg_sr_q;
        end
    end

    // Group pipeline stages load unconditionally so a config switch never shows stale data
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            p1_q  <= '0;
            p2_q  <= '0;
            p2b_q <= '0;
            p4_q  <= '0;
            pp4_q <= '0;
        end else begin
            p1_q  <= m1;
            p2_q  <= m2;
            p2b_q <= m2b;
            p4_q  <= m4;
            pp4_q <= mm4;
        end
    end

    // LFSR feedback taps and next signature (shift with polynomial fold, then mix S inputs)
    always_comb begin
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        sig_d   = {sig_q[W4-2:0], 1'b0}
                ^ (sig_q[W4-1] ? SIG_POLY : '0)
                ^ bus.S4END
                ^ {bus.S2END, bus.S2MID};
    end

    // Test sequencer: IDLE -> RUN for test_len cycles -> one DONE cycle -> IDLE
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            sig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.test_start && (bus.test_len != '0)) begin
                        state_q <= RUN;
                        cnt_q   <= bus.test_len;
                        lfsr_q  <= LFSR_SEED;
                        sig_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    lfsr_q <= {lfsr_q[W4-2:0], lfsr_fb};
                    cnt_q  <= cnt_q - LEN_W'(1);
                    sig_q  <= sig_d;
                    if (cnt_q == LEN_W'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // N-wire selection: passthrough or pipelined per group, overridden by the LFSR while testing
    always_comb begin
        n1_c  = cfg_act_q[0] ? p1_q  : m1;
        n2_c  = cfg_act_q[1] ? p2_q  : m2;
        n2b_c = cfg_act_q[1] ? p2b_q : m2b;
        n4_c  = cfg_act_q[2] ? p4_q  : m4;
        nn4_c = cfg_act_q[3] ? pp4_q : mm4;
        if (state_q == RUN) begin
            n4_c  = lfsr_q;
            nn4_c = ~lfsr_q;
            n2_c  = lfsr_q[W2-1:0];
            n2b_c = lfsr_q[W4-1:W2];
            n1_c  = lfsr_q[W1-1:0];
        end
    end

    assign bus.N1BEG     = n1_c;
    assign bus.N2BEG     = n2_c;
    assign bus.N2BEGb    = n2b_c;
    assign bus.N4BEG     = n4_c;
    assign bus.NN4BEG    = nn4_c;
    assign bus.cfg_dout  = cfg_sr_q[CFG_W-1];
    assign bus.test_busy = busy_q;
    assign bus.test_done = done_q;
    assign bus.sig_out   = sig_q;

endmodule

// File: tb/tb_s_term_dsp_loopback.sv
// Scoreboard bench for the S-terminal DSP loopback tile: directed stimulus
// pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_s_term_dsp_loopback;
    localparam int SEL_N1   = 0;
    localparam int SEL_N2   = 1;
    localparam int SEL_N2B  = 2;
    localparam int SEL_N4   = 3;
    localparam int SEL_NN4  = 4;
    localparam int SEL_DOUT = 5;
    localparam int SEL_BUSY = 6;
    localparam int SEL_DONE = 7;
    localparam int SEL_SIG  = 8;

    typedef struct {
        int unsigned due;
        int          sel;
        logic [15:0] exp;
        string       name;
    } chk_t;

    logic        UserCLK;
    logic        resetn;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    chk_t        sched_q[$];
    logic [15:0] run_q[$];
    logic [15:0] done_q[$];

    s_term_dsp_loopback_if bus ();

    s_term_dsp_loopback #(.LFSR_SEED(16'hACE1)) dut (
        .UserCLK (UserCLK),
        .resetn  (resetn),
        .bus     (bus)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    always @(posedge UserCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [15:0] get_val(input int sel);
        case (sel)
            SEL_N1:   return 16'(bus.N1BEG);
            SEL_N2:   return 16'(bus.N2BEG);
            SEL_N2B:  return 16'(bus.N2BEGb);
            SEL_N4:   return bus.N4BEG;
            SEL_NN4:  return bus.NN4BEG;
            SEL_DOUT: return 16'(bus.cfg_dout);
            SEL_BUSY: return 16'(bus.test_busy);
            SEL_DONE: return 16'(bus.test_done);
            default:  return bus.sig_out;
        endcase
    endfunction

    task automatic sched(input int unsigned due, input int sel, input logic [15:0] exp, input string name);
        chk_t it;
        it.due  = due;
        it.sel  = sel;
        it.exp  = exp;
        it.name = name;
        sched_q.push_back(it);
    endtask

    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    // Monitor: scheduled checks, per-busy-cycle LFSR output checks, per-done signature checks
    always @(negedge UserCLK) begin : mon
        chk_t        it;
        logic [15:0] e;
        while (sched_q.size() != 0 && sched_q[0].due == cyc) begin
            it = sched_q.pop_front();
            check(it.name, get_val(it.sel), it.exp);
        end
        if (bus.test_busy === 1'b1) begin
            if (run_q.size() == 0) begin
                check("busy_spurious", 16'(bus.test_busy), 16'h0);
            end else begin
                e = run_q.pop_front();
                check("run_n4",  bus.N4BEG,          e);
                check("run_nn4", bus.NN4BEG,         ~e);
                check("run_n2",  16'(bus.N2BEG),     {8'h00, e[7:0]});
                check("run_n2b", 16'(bus.N2BEGb),    {8'h00, e[15:8]});
                check("run_n1",  16'(bus.N1BEG),     {12'h000, e[3:0]});
            end
        end
        if (bus.test_done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("done_spurious", 16'(bus.test_done), 16'h0);
            end else begin
                e = done_q.pop_front();
                check("done_sig", bus.sig_out, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn         = 1'b0;
        bus.S1END      = '0;
        bus.S2MID      = '0;
        bus.S2END      = '0;
        bus.S4END      = '0;
        bus.SS4END     = '0;
        bus.cfg_shift  = 1'b0;
        bus.cfg_din    = 1'b0;
        bus.cfg_load   = 1'b0;
        bus.test_start = 1'b0;
        bus.test_len   = '0;
        tick();
        tick();

        // Passthrough while held in reset
        bus.S4END  = 16'h0001;
        bus.SS4END = 16'h00F0;
        bus.S1END  = 4'b0001;
        bus.S2MID  = 8'h01;
        bus.S2END  = 8'h03;
        sched(cyc, SEL_N4,   16'h8000, "rst_n4");
        sched(cyc, SEL_NN4,  16'h0F00, "rst_nn4");
        sched(cyc, SEL_N1,   16'h0008, "rst_n1");
        sched(cyc, SEL_N2,   16'h0080, "rst_n2");
        sched(cyc, SEL_N2B,  16'h00C0, "rst_n2b");
        sched(cyc, SEL_BUSY, 16'h0000, "rst_busy");
        sched(cyc, SEL_DONE, 16'h0000, "rst_done");
        sched(cyc, SEL_SIG,  16'h0000, "rst_sig");
        sched(cyc, SEL_DOUT, 16'h0000, "rst_dout");
        tick();
        resetn = 1'b1;
        sched(cyc, SEL_N4, 16'h8000, "pt_n4");
        tick();

        // Shift in 1,0,0,0 then load: only NN4 becomes pipelined
        bus.cfg_shift = 1'b1;
        bus.cfg_din   = 1'b1;
        tick();
        bus.cfg_din = 1'b0;
        tick();
        tick();
        sched(cyc, SEL_DOUT, 16'h0000, "dout_after3");
        tick();
        bus.cfg_shift = 1'b0;
        bus.cfg_load  = 1'b1;
        sched(cyc, SEL_DOUT, 16'h0001, "dout_after4");
        tick();
        bus.cfg_load = 1'b0;
        bus.SS4END   = 16'h0001;
        bus.S4END    = 16'h0002;
        sched(cyc,     SEL_NN4, 16'h0F00, "nn4_delay_old");
        sched(cyc,     SEL_N4,  16'h4000, "n4_direct");
        sched(cyc + 1, SEL_NN4, 16'h8000, "nn4_delay_new");
        tick();

        // Build cfg_sr = 0101, then shift 1 and load together
        bus.cfg_shift = 1'b1;
        bus.cfg_din   = 1'b0;
        tick();
        bus.cfg_din = 1'b1;
        tick();
        bus.cfg_din = 1'b0;
        tick();
        bus.cfg_din = 1'b1;
        tick();
        bus.cfg_load = 1'b1;
        sched(cyc, SEL_DOUT, 16'h0000, "dout_0101");
        tick();
        bus.cfg_load = 1'b0;
        bus.cfg_din  = 1'b0;
        bus.S1END    = 4'b0010;
        bus.S4END    = 16'h0004;
        bus.SS4END   = 16'h0010;
        bus.S2MID    = 8'h02;
        sched(cyc,     SEL_DOUT, 16'h0001, "dout_1011");
        sched(cyc,     SEL_N1,   16'h0008, "n1_reg_old");
        sched(cyc,     SEL_N4,   16'h4000, "n4_reg_old");
        sched(cyc,     SEL_NN4,  16'h0800, "nn4_direct");
        sched(cyc,     SEL_N2,   16'h0040, "n2_direct");
        sched(cyc,     SEL_N2B,  16'h00C0, "n2b_direct");
        sched(cyc + 1, SEL_DOUT, 16'h0000, "dout_0110");
        sched(cyc + 1, SEL_N1,   16'h0004, "n1_reg_new");
        sched(cyc + 1, SEL_N4,   16'h2000, "n4_reg_new");
        tick();
        bus.cfg_shift = 1'b0;

        // Test run len=3 with S inputs zero; start held through RUN and DONE
        bus.S1END  = '0;
        bus.S2MID  = '0;
        bus.S2END  = '0;
        bus.S4END  = '0;
        bus.SS4END = '0;
        tick();
        bus.test_start = 1'b1;
        bus.test_len   = 8'd3;
        run_q.push_back(16'hACE1);
        run_q.push_back(16'h59C3);
        run_q.push_back(16'hB387);
        done_q.push_back(16'h0000);
        sched(cyc,     SEL_BUSY, 16'h0000, "busy_pre");
        sched(cyc + 1, SEL_BUSY, 16'h0001, "busy_first");
        sched(cyc + 3, SEL_BUSY, 16'h0001, "busy_third");
        sched(cyc + 4, SEL_BUSY, 16'h0000, "busy_after");
        sched(cyc + 4, SEL_DONE, 16'h0001, "done_pulse");
        sched(cyc + 5, SEL_DONE, 16'h0000, "done_one_cycle");
        sched(cyc + 5, SEL_SIG,  16'h0000, "sig_zero");
        sched(cyc + 6, SEL_BUSY, 16'h0000, "busy_no_restart");
        tick();
        bus.test_len = 8'd9;
        tick();
        tick();
        tick();
        tick();
        bus.test_start = 1'b0;
        tick();
        tick();
        tick();

        // Signature with polynomial fold: S4END=8000, len=2 -> 8000, E801
        bus.S4END      = 16'h8000;
        bus.test_start = 1'b1;
        bus.test_len   = 8'd2;
        run_q.push_back(16'hACE1);
        run_q.push_back(16'h59C3);
        done_q.push_back(16'hE801);
        sched(cyc + 3, SEL_DONE, 16'h0001, "done_len2");
        tick();
        bus.test_start = 1'b0;
        tick();
        tick();
        tick();
        tick();

        // Signature from the 2-wire inputs: len=1 -> {S2END,S2MID}
        bus.S4END      = 16'h0000;
        bus.S2END      = 8'h12;
        bus.S2MID      = 8'h34;
        bus.test_start = 1'b1;
        bus.test_len   = 8'd1;
        run_q.push_back(16'hACE1);
        done_q.push_back(16'h1234);
        tick();
        bus.test_start = 1'b0;
        tick();
        tick();
        tick();

        // Zero-length start ignored; signature held
        bus.test_start = 1'b1;
        bus.test_len   = 8'd0;
        sched(cyc + 1, SEL_BUSY, 16'h0000, "len0_busy1");
        sched(cyc + 2, SEL_BUSY, 16'h0000, "len0_busy2");
        sched(cyc + 2, SEL_SIG,  16'h1234, "len0_sig_hold");
        tick();
        tick();
        bus.test_start = 1'b0;
        tick();

        // Reset asserted mid-RUN aborts with no done pulse
        bus.S2END      = '0;
        bus.S2MID      = '0;
        bus.S4END      = 16'h0001;
        bus.test_start = 1'b1;
        bus.test_len   = 8'd5;
        run_q.push_back(16'hACE1);
        run_q.push_back(16'h59C3);
        tick();
        bus.test_start = 1'b0;
        tick();
        tick();
        resetn = 1'b0;
        sched(cyc, SEL_BUSY, 16'h0000, "abort_busy");
        sched(cyc, SEL_DONE, 16'h0000, "abort_done");
        sched(cyc, SEL_SIG,  16'h0000, "abort_sig");
        sched(cyc, SEL_N4,   16'h8000, "abort_passthrough");
        tick();
        resetn = 1'b1;
        sched(cyc + 3, SEL_DONE, 16'h0000, "abort_no_done");
        sched(cyc + 3, SEL_SIG,  16'h0000, "abort_sig_later");
        for (int i = 0; i < 6; i++) tick();

        check("run_q_drained",   16'(run_q.size()),   16'h0);
        check("done_q_drained",  16'(done_q.size()),  16'h0);
        check("sched_q_drained", 16'(sched_q.size()), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/s_term_dsp_loopback.md
S_TERM_DSP_LOOPBACK -- requirements
Module: s_term_dsp_loopback

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1: test-pattern LFSR load value; never zero.
REQ-002 SHALL have port UserCLK, input, 1: the single clock; all flops rising-edge.
REQ-003 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have S-wire inputs:
- S1END, input, 4
- S2MID, input, 8
- S2END, input, 8
- S4END, input, 16
- SS4END, input, 16
REQ-005 SHALL have N-wire outputs:
- N1BEG, output, 4
- N2BEG, output, 8
- N2BEGb, output, 8
- N4BEG, output, 16
- NN4BEG, output, 16
REQ-006 SHALL have config ports:
- cfg_shift, input, 1
- cfg_din, input, 1
- cfg_load, input, 1
- cfg_dout, output, 1
REQ-007 SHALL have test ports:
- test_start, input, 1
- test_len, input, 8
- test_busy, output, 1
- test_done, output, 1
- sig_out, output, 16

Function
REQ-008 SHALL form mapped values with index reversal:
- m1[i]=S1END[3-i]
- m2[i]=S2MID[7-i]
- m2b[i]=S2END[7-i]
- m4[i]=S4END[15-i]
- mm4[i]=SS4END[15-i]
REQ-009 SHALL hold a 4-bit shift register cfg_sr, updated on cfg_shift as cfg_sr <= {cfg_sr[2:0], cfg_din}; cfg_dout = cfg_sr[3].
REQ-010 SHALL copy cfg_sr to active config cfg_act on cfg_load; with cfg_load and cfg_shift in the same cycle, cfg_act SHALL take the pre-shift cfg_sr.
REQ-011 SHALL assign cfg_act bits to groups:
- bit0: N1
- bit1: N2 and N2b
- bit2: N4
- bit3: NN4
REQ-012 SHALL drive a group's outputs combinationally from its mapped value (0 latency) when its cfg_act bit is 0, and from a register of that value (1-cycle latency) when the bit is 1.
REQ-013 SHALL keep group pipeline registers loading every cycle regardless of config, so a config change takes effect with no stale bubble beyond one cycle.
REQ-014 SHALL implement test FSM states IDLE, RUN, DONE.
REQ-015 SHALL move IDLE->RUN on test_start=1 with test_len!=0, loading counter=test_len, lfsr=LFSR_SEED and sig=0.
REQ-016 SHALL ignore test_start with test_len=0, and test_start while in RUN or DONE.
REQ-017 SHALL, in each RUN cycle:
- shift lfsr left with feedback bit0 = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]
- decrement counter
- update sig <= ({sig[14:0],1'b0} ^ (sig[15] ? 16'h6801 : 0)) ^ S4END ^ {S2END,S2MID}
REQ-018 SHALL move RUN->DONE on the cycle the counter decrements from 1, so RUN lasts exactly test_len cycles; DONE SHALL last one cycle, then go to IDLE.
REQ-019 SHALL, in RUN, override all config and drive outputs from the current lfsr register:
- N4BEG=lfsr
- NN4BEG=~lfsr
- N2BEG=lfsr[7:0]
- N2BEGb=lfsr[15:8]
- N1BEG=lfsr[3:0]
REQ-020 SHALL set test_busy=1 exactly in RUN and test_done=1 exactly in DONE.
REQ-021 SHALL drive sig_out=sig, holding its value from DONE until the next accepted start.

Reset
REQ-022 SHALL, on resetn low, asynchronously clear to zero:
- cfg_sr, cfg_act
- pipeline registers, counter, sig
- test_busy, test_done
REQ-023 SHALL, on resetn low, set FSM=IDLE and lfsr=LFSR_SEED; outputs then follow the combinational passthrough.
REQ-024 SHALL, on reset asserted mid-RUN, abort the test immediately with no test_done pulse.

Verification
REQ-025 SHALL cover passthrough: reset, S4END=16'h0001 -> N4BEG=16'h8000 in the same cycle; SS4END=16'h00F0 -> NN4BEG=16'h0F00.
REQ-026 SHALL cover config: shift in 1,0,0,0, then cfg_load -> cfg_act=4'b1000; NN4 delayed one cycle, other groups unregistered; cfg_dout=1 after the fourth further shift.
REQ-027 SHALL cover simultaneous events: cfg_sr=4'b0101 with cfg_shift, cfg_din=1 and cfg_load together -> cfg_act=4'b0101, cfg_sr=4'b1011.
REQ-028 SHALL cover the test run: test_len=3 with S inputs zero -> busy for 3 cycles; N4BEG=16'hACE1, 16'h59C3, 16'hB387; one-cycle done; sig_out=0.
REQ-029 SHALL cover ignored starts and reset abort:
- test_len=0 start -> FSM stays IDLE
- start during RUN -> counter unchanged
- resetn low mid-RUN -> busy=0, done never pulses, sig_out=0
